// File: rtl/pcie_cpl_tx_if.sv
// Request-side and PCIe-core-side signals of the completion transmitter.
// slave = the transmitter itself, master = the request source plus PCIe core.
interface pcie_cpl_tx_if;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_rid;
    logic [7:0]  req_tag;
    logic [6:0]  req_lowaddr;
    logic [31:0] req_data;
    logic        req_ur;
    logic [7:0]  bus_num;
    logic [4:0]  dev_num;
    logic [2:0]  func_num;
    logic        tx_req;
    logic        tx_rdy;
    logic        tx_st;
    logic        tx_end;
    logic [15:0] tx_data;
    logic [8:0]  tx_ca_cplh;
    logic [12:0] tx_ca_cpld;
    logic        tx_ca_cpl_recheck;
    logic        cpl_sent;

    modport slave (
        input  req_valid, req_rid, req_tag, req_lowaddr, req_data, req_ur,
        input  bus_num, dev_num, func_num,
        input  tx_rdy, tx_ca_cplh, tx_ca_cpld, tx_ca_cpl_recheck,
        output req_ready, tx_req, tx_st, tx_end, tx_data, cpl_sent
    );

    modport master (
        output req_valid, req_rid, req_tag, req_lowaddr, req_data, req_ur,
        output bus_num, dev_num, func_num,
        output tx_rdy, tx_ca_cplh, tx_ca_cpld, tx_ca_cpl_recheck,
        input  req_ready, tx_req, tx_st, tx_end, tx_data, cpl_sent
    );
endinterface

// File: rtl/pcie_cpl_tx.sv
// Sends a 1-DW CplD (or a data-less UR Cpl) as 16-bit beats; capture -> credit wait -> tx_req -> beats.
// Stalls in WAIT_CR until credits exist, holds the current beat while tx_rdy=0; req_ready only in IDLE.
module pcie_cpl_tx #(
    parameter bit CREDIT_INF = 1'b1
) (
    input  logic         pcie_clk,
    input  logic         sys_rst_n,
    pcie_cpl_tx_if.slave cpl_if
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_CR = 2'd1,
        REQ     = 2'd2,
        SEND    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  beat_q, beat_d;
    logic        req_ready_q, req_ready_d;
    logic        tx_req_q, tx_req_d;
    logic        tx_st_q, tx_st_d;
    logic        tx_end_q, tx_end_d;
    logic [15:0] tx_data_q, tx_data_d;
    logic        cpl_sent_q, cpl_sent_d;

    logic        ur_q, ur_d;
    logic [15:0] rid_q, rid_d;
    logic [7:0]  tag_q, tag_d;
    logic [6:0]  lowaddr_q, lowaddr_d;
    logic [31:0] data_q, data_d;
    logic [15:0] cid_q, cid_d;

    logic [2:0]  last_beat;
    logic        cplh_ok;
    logic        cpld_ok;
    logic        credit_ok;
    logic [15:0] beat_word;

    // MSB of a credit count means "infinite" when CREDIT_INF is set.
    assign cplh_ok   = (CREDIT_INF && cpl_if.tx_ca_cplh[8])  || (cpl_if.tx_ca_cplh != 9'd0);
    assign cpld_ok   = (CREDIT_INF && cpl_if.tx_ca_cpld[12]) || (cpl_if.tx_ca_cpld != 13'd0);
    assign credit_ok = cplh_ok && (ur_q || cpld_ok);
    assign last_beat = ur_q ? 3'd5 : 3'd7;

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        cpl_sent_d = 1'b0;
        ur_d       = ur_q;
        rid_d      = rid_q;
        tag_d      = tag_q;
        lowaddr_d  = lowaddr_q;
        data_d     = data_q;
        cid_d      = cid_q;
        case (state_q)
            IDLE: begin
                if (cpl_if.req_valid && req_ready_q) begin
                    ur_d      = cpl_if.req_ur;
                    rid_d     = cpl_if.req_rid;
                    tag_d     = cpl_if.req_tag;
                    lowaddr_d = cpl_if.req_lowaddr;
                    data_d    = cpl_if.req_data;
                    cid_d     = {cpl_if.bus_num, cpl_if.dev_num, cpl_if.func_num};
                    state_d   = WAIT_CR;
                end
            end
            WAIT_CR: begin
                if (credit_ok) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                // A credit recheck wins over a simultaneous grant.
                if (cpl_if.tx_ca_cpl_recheck) begin
                    state_d = WAIT_CR;
                end else if (cpl_if.tx_rdy) begin
                    state_d = SEND;
                    beat_d  = 3'd0;
                end
            end
            SEND: begin
                if (cpl_if.tx_rdy) begin
                    if (beat_q == last_beat) begin
                        state_d    = IDLE;
                        beat_d     = 3'd0;
                        cpl_sent_d = 1'b1;
                    end else begin
                        beat_d = beat_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Header is fixed apart from format/type, length and status; UR carries no data.
    always_comb begin
        beat_word = 16'h0000;
        case (beat_d)
            3'd0: beat_word = ur_q ? 16'h0A00 : 16'h4A00;
            3'd1: beat_word = ur_q ? 16'h0000 : {6'b000000, 10'd1};
            3'd2: beat_word = cid_q;
            3'd3: beat_word = {(ur_q ? 3'b001 : 3'b000), 1'b0, 12'd4};
            3'd4: beat_word = rid_q;
            3'd5: beat_word = {tag_q, 1'b0, lowaddr_q};
            3'd6: beat_word = data_q[31:16];
            3'd7: beat_word = data_q[15:0];
        endcase
    end

    always_comb begin
        req_ready_d = (state_d == IDLE);
        tx_req_d    = (state_d == REQ);
        tx_st_d     = (state_d == SEND) && (beat_d == 3'd0);
        tx_end_d    = (state_d == SEND) && (beat_d == last_beat);
        tx_data_d   = (state_d == SEND) ? beat_word : 16'h0000;
    end

    always_ff @(posedge pcie_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= IDLE;
            beat_q      <= 3'd0;
            req_ready_q <= 1'b0;
            tx_req_q    <= 1'b0;
            tx_st_q     <= 1'b0;
            tx_end_q    <= 1'b0;
            tx_data_q   <= 16'h0000;
            cpl_sent_q  <= 1'b0;
            ur_q        <= 1'b0;
            rid_q       <= 16'h0000;
            tag_q       <= 8'h00;
            lowaddr_q   <= 7'h00;
            data_q      <= 32'h0000_0000;
            cid_q       <= 16'h0000;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            req_ready_q <= req_ready_d;
            tx_req_q    <= tx_req_d;
            tx_st_q     <= tx_st_d;
            tx_end_q    <= tx_end_d;
            tx_data_q   <= tx_data_d;
            cpl_sent_q  <= cpl_sent_d;
            ur_q        <= ur_d;
            rid_q       <= rid_d;
            tag_q       <= tag_d;
            lowaddr_q   <= lowaddr_d;
            data_q      <= data_d;
            cid_q       <= cid_d;
        end
    end

    assign cpl_if.req_ready = req_ready_q;
    assign cpl_if.tx_req    = tx_req_q;
    assign cpl_if.tx_st     = tx_st_q;
    assign cpl_if.tx_end    = tx_end_q;
    assign cpl_if.tx_data   = tx_data_q;
    assign cpl_if.cpl_sent  = cpl_sent_q;

endmodule

// File: tb/tb_pcie_cpl_tx.sv
// Bench for pcie_cpl_tx: directed scenarios plus randomized TLPs against a DW-level completion model.
module tb_pcie_cpl_tx;

    logic pcie_clk = 1'b0;
    logic sys_rst_n;
    always #5 pcie_clk = ~pcie_clk;

    pcie_cpl_tx_if cif ();

    pcie_cpl_tx #(.CREDIT_INF(1'b1)) dut (
        .pcie_clk (pcie_clk),
        .sys_rst_n(sys_rst_n),
        .cpl_if   (cif.slave)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] exp_q[$];
    logic [15:0] obs_dat[$];
    bit          obs_st[$];
    bit          obs_end[$];
    int          n_cpl, cpl_post, idle_nz, hold_err, hold_cnt, req_in_send;
    bit          timed_out;

    logic [15:0] f_rid;
    logic [7:0]  f_tag;
    logic [6:0]  f_la;
    logic [31:0] f_data;
    logic        f_ur;
    logic [7:0]  f_bus;
    logic [4:0]  f_dev;
    logic [2:0]  f_func;

    // Reference model: build the TLP as DWs, then emit upper half first.
    task automatic model_tlp();
        logic [31:0] dw [4];
        int ndw;
        dw[0] = f_ur ? 32'h0A00_0000 : 32'h4A00_0001;
        dw[1] = {f_bus, f_dev, f_func, (f_ur ? 3'b001 : 3'b000), 1'b0, 12'd4};
        dw[2] = {f_rid, f_tag, 1'b0, f_la};
        dw[3] = f_data;
        ndw = f_ur ? 3 : 4;
        exp_q.delete();
        for (int i = 0; i < ndw; i++) begin
            exp_q.push_back(dw[i][31:16]);
            exp_q.push_back(dw[i][15:0]);
        end
    endtask

    task automatic set_fixed(input logic ur);
        f_bus = 8'd3; f_dev = 5'd0; f_func = 3'd0;
        f_rid = 16'h0100; f_tag = 8'h12; f_la = 7'h04;
        f_data = 32'hDEADBEEF; f_ur = ur;
    endtask

    task automatic rand_fields();
        f_bus = 8'($urandom); f_dev = 5'($urandom); f_func = 3'($urandom);
        f_rid = 16'($urandom); f_tag = 8'($urandom); f_la = 7'($urandom);
        f_data = $urandom; f_ur = 1'($urandom_range(1));
    endtask

    // Called on a negedge; returns on the negedge after the capture edge.
    task automatic issue_req();
        int waited;
        waited = 0;
        while (cif.req_ready !== 1'b1 && waited < 50) begin
            @(negedge pcie_clk);
            waited++;
        end
        if (cif.req_ready !== 1'b1) begin
            vectors++; miscompares++;
            $display("FAIL issue_req_timeout: req_ready=%b want 1", cif.req_ready);
        end
        cif.req_rid = f_rid; cif.req_tag = f_tag; cif.req_lowaddr = f_la;
        cif.req_data = f_data; cif.req_ur = f_ur;
        cif.bus_num = f_bus; cif.dev_num = f_dev; cif.func_num = f_func;
        cif.req_valid = 1'b1;
        model_tlp();
        @(negedge pcie_clk);
        cif.req_valid = 1'b0;
        cif.req_rid = 16'($urandom); cif.req_tag = 8'($urandom); cif.req_lowaddr = 7'($urandom);
        cif.req_data = $urandom; cif.req_ur = 1'($urandom_range(1));
        cif.bus_num = 8'($urandom); cif.dev_num = 5'($urandom); cif.func_num = 3'($urandom);
    endtask

    // Drives tx_rdy and records accepted beats; hold_at/hold_len force tx_rdy=0 on one beat.
    task automatic collect(input int rdy_pct, input int hold_at, input int hold_len, input int max_cyc);
        bit in_tlp, pres, rdy, end_seen, prev_pres, prev_rdy;
        logic [15:0] prev_dat;
        int post, hold_left;
        in_tlp = 0; end_seen = 0; prev_pres = 0; prev_rdy = 0; prev_dat = 16'h0;
        post = 0; hold_left = hold_len;
        obs_dat.delete(); obs_st.delete(); obs_end.delete();
        n_cpl = 0; cpl_post = 0; idle_nz = 0; hold_err = 0; hold_cnt = 0; req_in_send = 0;
        for (int c = 0; c < max_cyc && post < 3; c++) begin
            if (end_seen) post++;
            if (cif.cpl_sent) begin
                n_cpl++;
                cpl_post = post;
            end
            if (cif.tx_st && !end_seen) in_tlp = 1;
            pres = in_tlp;
            if (!pres && cif.tx_data !== 16'h0000) idle_nz++;
            if (pres && cif.tx_req) req_in_send++;
            if (pres && prev_pres && !prev_rdy && cif.tx_data !== prev_dat) hold_err++;
            if (pres && obs_dat.size() == hold_at) hold_cnt++;
            if (pres && obs_dat.size() == hold_at && hold_left > 0) begin
                rdy = 0;
                hold_left--;
            end else begin
                rdy = ($urandom_range(99) < rdy_pct);
            end
            cif.tx_rdy = rdy;
            prev_pres = pres; prev_rdy = rdy; prev_dat = cif.tx_data;
            if (pres && rdy) begin
                obs_dat.push_back(cif.tx_data);
                obs_st.push_back(cif.tx_st);
                obs_end.push_back(cif.tx_end);
                if (cif.tx_end || obs_dat.size() >= 8) begin
                    in_tlp = 0;
                    end_seen = 1;
                    prev_pres = 0;
                end
            end
            @(negedge pcie_clk);
        end
        cif.tx_rdy = 1'b0;
        timed_out = (post < 3);
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        repeat (2) @(negedge pcie_clk);
        vectors++;
        if ({cif.req_ready, cif.tx_req, cif.tx_st, cif.tx_end, cif.cpl_sent, cif.tx_data} !== 21'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: rdy%b req%b st%b end%b cpl%b dat%h want all 0",
                     cif.req_ready, cif.tx_req, cif.tx_st, cif.tx_end, cif.cpl_sent, cif.tx_data);
        end
        sys_rst_n = 1'b1;
        #1;
        vectors++;
        if (cif.req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release_early: req_ready=%b want 0", cif.req_ready);
        end
        @(negedge pcie_clk);
        vectors++;
        if (cif.req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_ready: req_ready=%b want 1", cif.req_ready);
        end
    endtask

    task automatic test_cpld();
        set_fixed(1'b0);
        issue_req();
        cif.tx_rdy = 1'b0;
        @(negedge pcie_clk);
        vectors++;
        if (cif.tx_req !== 1'b1) begin
            miscompares++;
            $display("FAIL cpld_tx_req: got %b want 1", cif.tx_req);
        end
        collect(100, -1, 0, 200);
        vectors++;
        if (obs_dat.size() != exp_q.size() || timed_out) begin
            miscompares++;
            $display("FAIL cpld_len: got %0d beats (timeout %b) want %0d", obs_dat.size(), timed_out, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_dat.size(); i++) begin
            vectors++;
            if (obs_dat[i] !== exp_q[i] || obs_st[i] !== (i == 0) || obs_end[i] !== (i == exp_q.size() - 1)) begin
                miscompares++;
                $display("FAIL cpld_beat%0d: got %h st%b end%b want %h st%b end%b", i,
                         obs_dat[i], obs_st[i], obs_end[i], exp_q[i], (i == 0), (i == exp_q.size() - 1));
            end
        end
        vectors++;
        if (n_cpl != 1 || cpl_post != 1) begin
            miscompares++;
            $display("FAIL cpld_cpl_sent: got %0d pulses at +%0d want 1 at +1", n_cpl, cpl_post);
        end
        vectors++;
        if (idle_nz != 0 || hold_err != 0 || req_in_send != 0 || cif.req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL cpld_side: idle_nz %0d hold_err %0d req_in_send %0d req_ready %b want 0 0 0 1",
                     idle_nz, hold_err, req_in_send, cif.req_ready);
        end
    endtask

    task automatic test_ur();
        set_fixed(1'b1);
        issue_req();
        collect(60, -1, 0, 300);
        vectors++;
        if (obs_dat.size() != 6 || timed_out) begin
            miscompares++;
            $display("FAIL ur_len: got %0d beats (timeout %b) want 6", obs_dat.size(), timed_out);
        end
        for (int i = 0; i < exp_q.size() && i < obs_dat.size(); i++) begin
            vectors++;
            if (obs_dat[i] !== exp_q[i] || obs_st[i] !== (i == 0) || obs_end[i] !== (i == exp_q.size() - 1)) begin
                miscompares++;
                $display("FAIL ur_beat%0d: got %h st%b end%b want %h st%b end%b", i,
                         obs_dat[i], obs_st[i], obs_end[i], exp_q[i], (i == 0), (i == exp_q.size() - 1));
            end
        end
        vectors++;
        if (n_cpl != 1 || cpl_post != 1 || hold_err != 0 || idle_nz != 0) begin
            miscompares++;
            $display("FAIL ur_side: cpl %0d at +%0d hold_err %0d idle_nz %0d want 1 +1 0 0",
                     n_cpl, cpl_post, hold_err, idle_nz);
        end
    endtask

    task automatic test_credit_stall();
        int req_seen;
        set_fixed(1'b0);
        cif.tx_ca_cpld = 13'd0;
        cif.tx_rdy = 1'b0;
        issue_req();
        req_seen = 0;
        repeat (20) begin
            @(negedge pcie_clk);
            if (cif.tx_req) req_seen++;
        end
        vectors++;
        if (req_seen != 0) begin
            miscompares++;
            $display("FAIL credit_stall: tx_req high %0d of 20 cycles want 0", req_seen);
        end
        cif.tx_ca_cpld = 13'd1;
        @(negedge pcie_clk);
        vectors++;
        if (cif.tx_req !== 1'b1) begin
            miscompares++;
            $display("FAIL credit_release: tx_req=%b want 1", cif.tx_req);
        end
        collect(100, -1, 0, 200);
        vectors++;
        if (obs_dat != exp_q || n_cpl != 1) begin
            miscompares++;
            $display("FAIL credit_tlp: got %0d beats %0d cpl want %0d beats 1 cpl", obs_dat.size(), n_cpl, exp_q.size());
        end
        // Infinite credit encodings must not stall.
        cif.tx_ca_cpld = 13'h1000;
        cif.tx_ca_cplh = 9'h100;
        rand_fields();
        f_ur = 1'b0;
        issue_req();
        @(negedge pcie_clk);
        vectors++;
        if (cif.tx_req !== 1'b1) begin
            miscompares++;
            $display("FAIL inf_credit: tx_req=%b want 1", cif.tx_req);
        end
        collect(100, -1, 0, 200);
        vectors++;
        if (obs_dat != exp_q || n_cpl != 1) begin
            miscompares++;
            $display("FAIL inf_tlp: got %0d beats %0d cpl want %0d beats 1 cpl", obs_dat.size(), n_cpl, exp_q.size());
        end
        cif.tx_ca_cplh = 9'd8;
        cif.tx_ca_cpld = 13'd64;
    endtask

    task automatic test_rdy_hold();
        set_fixed(1'b0);
        issue_req();
        collect(100, 4, 3, 200);
        vectors++;
        if (hold_cnt != 4 || hold_err != 0) begin
            miscompares++;
            $display("FAIL hold_beat4: presented %0d cycles hold_err %0d want 4 and 0", hold_cnt, hold_err);
        end
        vectors++;
        if (obs_dat.size() < 5 || obs_dat[4] !== 16'h0100) begin
            miscompares++;
            $display("FAIL hold_value: got %0d beats beat4 %h want 0100", obs_dat.size(),
                     (obs_dat.size() > 4) ? obs_dat[4] : 16'hxxxx);
        end
        vectors++;
        if (obs_dat != exp_q || n_cpl != 1) begin
            miscompares++;
            $display("FAIL hold_tlp: got %0d beats %0d cpl want %0d beats 1 cpl", obs_dat.size(), n_cpl, exp_q.size());
        end
    endtask

    task automatic test_recheck();
        set_fixed(1'b0);
        cif.tx_rdy = 1'b0;
        issue_req();
        @(negedge pcie_clk);
        vectors++;
        if (cif.tx_req !== 1'b1) begin
            miscompares++;
            $display("FAIL recheck_pre: tx_req=%b want 1", cif.tx_req);
        end
        cif.tx_ca_cpl_recheck = 1'b1;
        cif.tx_rdy = 1'b1;
        @(negedge pcie_clk);
        cif.tx_ca_cpl_recheck = 1'b0;
        cif.tx_rdy = 1'b0;
        vectors++;
        if (cif.tx_req !== 1'b0 || cif.tx_st !== 1'b0) begin
            miscompares++;
            $display("FAIL recheck_drop: tx_req=%b tx_st=%b want 0 0", cif.tx_req, cif.tx_st);
        end
        @(negedge pcie_clk);
        vectors++;
        if (cif.tx_req !== 1'b1) begin
            miscompares++;
            $display("FAIL recheck_rereq: tx_req=%b want 1", cif.tx_req);
        end
        collect(100, -1, 0, 200);
        vectors++;
        if (obs_dat != exp_q || n_cpl != 1) begin
            miscompares++;
            $display("FAIL recheck_tlp: got %0d beats %0d cpl want %0d beats 1 cpl", obs_dat.size(), n_cpl, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int waited, bad;
        set_fixed(1'b0);
        issue_req();
        cif.tx_rdy = 1'b1;
        waited = 0;
        while (cif.tx_st !== 1'b1 && waited < 20) begin
            @(negedge pcie_clk);
            waited++;
        end
        repeat (5) @(negedge pcie_clk);
        vectors++;
        if (cif.tx_data !== 16'h1204) begin
            miscompares++;
            $display("FAIL rstmid_beat5: got %h want 1204", cif.tx_data);
        end
        sys_rst_n = 1'b0;
        cif.tx_rdy = 1'b0;
        #1;
        vectors++;
        if ({cif.req_ready, cif.tx_req, cif.tx_st, cif.tx_end, cif.cpl_sent, cif.tx_data} !== 21'h0) begin
            miscompares++;
            $display("FAIL rstmid_outputs: rdy%b req%b st%b end%b cpl%b dat%h want all 0",
                     cif.req_ready, cif.tx_req, cif.tx_st, cif.tx_end, cif.cpl_sent, cif.tx_data);
        end
        bad = 0;
        repeat (3) begin
            @(negedge pcie_clk);
            if (cif.tx_end || cif.cpl_sent) bad++;
        end
        sys_rst_n = 1'b1;
        repeat (2) begin
            @(negedge pcie_clk);
            if (cif.tx_end || cif.cpl_sent) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL rstmid_no_end: saw tx_end/cpl_sent %0d times want 0", bad);
        end
        rand_fields();
        issue_req();
        collect(80, -1, 0, 300);
        vectors++;
        if (obs_dat != exp_q || obs_st.size() == 0 || obs_st[0] !== 1'b1 || n_cpl != 1) begin
            miscompares++;
            $display("FAIL rstmid_next_tlp: got %0d beats %0d cpl want %0d beats 1 cpl from beat 0",
                     obs_dat.size(), n_cpl, exp_q.size());
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 25; t++) begin
            rand_fields();
            cif.tx_ca_cplh = 9'($urandom_range(1, 511));
            cif.tx_ca_cpld = f_ur ? 13'($urandom_range(0, 3)) : 13'($urandom_range(1, 8191));
            issue_req();
            collect(int'($urandom_range(20, 100)), -1, 0, 400);
            vectors++;
            if (obs_dat.size() != exp_q.size() || timed_out) begin
                miscompares++;
                $display("FAIL rand%0d_len: got %0d beats (timeout %b) want %0d", t, obs_dat.size(), timed_out, exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < obs_dat.size(); i++) begin
                vectors++;
                if (obs_dat[i] !== exp_q[i] || obs_st[i] !== (i == 0) || obs_end[i] !== (i == exp_q.size() - 1)) begin
                    miscompares++;
                    $display("FAIL rand%0d_beat%0d: got %h st%b end%b want %h st%b end%b", t, i,
                             obs_dat[i], obs_st[i], obs_end[i], exp_q[i], (i == 0), (i == exp_q.size() - 1));
                end
            end
            vectors++;
            if (n_cpl != 1 || cpl_post != 1 || idle_nz != 0 || hold_err != 0 || req_in_send != 0) begin
                miscompares++;
                $display("FAIL rand%0d_side: cpl %0d at +%0d idle_nz %0d hold_err %0d req_in_send %0d want 1 +1 0 0 0",
                         t, n_cpl, cpl_post, idle_nz, hold_err, req_in_send);
            end
        end
        cif.tx_ca_cplh = 9'd8;
        cif.tx_ca_cpld = 13'd64;
    endtask

    initial begin
        sys_rst_n = 1'b0;
        cif.req_valid = 1'b0;
        cif.req_rid = 16'h0; cif.req_tag = 8'h0; cif.req_lowaddr = 7'h0;
        cif.req_data = 32'h0; cif.req_ur = 1'b0;
        cif.bus_num = 8'h0; cif.dev_num = 5'h0; cif.func_num = 3'h0;
        cif.tx_rdy = 1'b0;
        cif.tx_ca_cplh = 9'd8;
        cif.tx_ca_cpld = 13'd64;
        cif.tx_ca_cpl_recheck = 1'b0;
        test_reset();
        test_cpld();
        test_ur();
        test_credit_stall();
        test_rdy_hold();
        test_recheck();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors %0d miscompares", vectors, miscompares);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pcie_cpl_tx.md
PCIE_CPL_TX -- requirements
Module: pcie_cpl_tx

Interface
REQ-001 SHALL have parameter CREDIT_INF default 1: when 1, a tx_ca_cplh or tx_ca_cpld value with MSB set counts as infinite credit.
REQ-002 SHALL have port: pcie_clk  in  1  single clock, all logic on rising edge.
REQ-003 SHALL have port: sys_rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port: req_valid  in  1  completion request present.
REQ-005 SHALL have port: req_ready  out  1  block can accept a request.
REQ-006 SHALL have port: req_rid  in  16  requester ID.
REQ-007 SHALL have port: req_tag  in  8  request tag.
REQ-008 SHALL have port: req_lowaddr  in  7  lower address.
REQ-009 SHALL have port: req_data  in  32  read data, 1 DW.
REQ-010 SHALL have port: req_ur  in  1  1 = unsupported request, send Cpl with status UR and no data.
REQ-011 SHALL have ports: bus_num in 8, dev_num in 5, func_num in 3  completer ID.
REQ-012 SHALL have ports: tx_req out 1, tx_rdy in 1, tx_st out 1, tx_end out 1, tx_data out 16  PCIe core transmit interface.
REQ-013 SHALL have ports: tx_ca_cplh in 9, tx_ca_cpld in 13, tx_ca_cpl_recheck in 1  completion credits.
REQ-014 SHALL have port: cpl_sent  out  1  one-cycle pulse per completed TLP.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT_CR, REQ, SEND.
REQ-016 SHALL drive req_ready=1 only in IDLE; on req_valid&req_ready, capture all req_* inputs and go to WAIT_CR next cycle.
REQ-017 SHALL ignore req_* inputs outside the capture cycle; captured fields stay stable until return to IDLE.
REQ-018 SHALL leave WAIT_CR for REQ when tx_ca_cplh>=1 and (req_ur or tx_ca_cpld>=1), applying CREDIT_INF to the MSB; otherwise stay in WAIT_CR indefinitely.
REQ-019 SHALL hold tx_req=1 throughout REQ and 0 in all other states.
REQ-020 In REQ, tx_ca_cpl_recheck=1 SHALL return the FSM to WAIT_CR; this takes priority over tx_rdy in the same cycle.
REQ-021 In REQ, tx_rdy=1 without recheck SHALL move the FSM to SEND and present beat 0 with tx_st=1 on the next cycle.
REQ-022 SHALL advance one beat per cycle in SEND while tx_rdy=1 and hold the current beat, tx_st and tx_end while tx_rdy=0.
REQ-023 CplD beats (8), upper half of each DW first: {8'h4A,8'h00}, {6'b0,10'd1}, {bus,dev,func}, {3'b000,1'b0,12'd4}, rid, {tag,1'b0,lowaddr}, data[31:16], data[15:0].
REQ-024 Cpl (UR) beats (6): {8'h0A,8'h00}, 16'h0000, {bus,dev,func}, {3'b001,1'b0,12'd4}, rid, {tag,1'b0,lowaddr}.
REQ-025 SHALL assert tx_st only with beat 0 and tx_end only with the last beat; both SHALL be 0 otherwise.
REQ-026 SHALL sample bus_num/dev_num/func_num at capture time.
REQ-027 SHALL go to IDLE on the cycle after the last beat is accepted (presented with tx_rdy=1), with cpl_sent=1 for exactly that cycle.
REQ-028 The beat counter SHALL be 3 bits, reset to 0 at each new TLP, with no wrap within a TLP.
REQ-029 tx_data SHALL be 16'h0000 whenever not in SEND.

Reset
REQ-030 sys_rst_n=0 SHALL immediately force state IDLE, req_ready=0 while asserted, and tx_req=tx_st=tx_end=cpl_sent=0, tx_data=0, beat counter=0.
REQ-031 After release, req_ready SHALL become 1 on the first clock edge.
REQ-032 Reset during SEND SHALL discard the TLP; no tx_end and no cpl_sent are issued for it.

Verification
REQ-033 Stimulus: bus=3, dev=0, func=0, rid=16'h0100, tag=8'h12, lowaddr=7'h04, data=32'hDEADBEEF, credits available, tx_rdy=1. Response: tx_data 4A00,0001,0300,0004,0100,1204,DEAD,BEEF; tx_st on beat 0, tx_end on BEEF, then one cpl_sent pulse.
REQ-034 Stimulus: same fields with req_ur=1. Response: tx_data 0A00,0000,0300,2004,0100,1204 and tx_end on 1204.
REQ-035 Stimulus: tx_ca_cpld=0 for 20 cycles, then 1. Response: tx_req=0 for those 20 cycles, then asserted; with tx_ca_cpld=13'h1000 and CREDIT_INF=1, no stall.
REQ-036 Stimulus: tx_rdy=0 for 3 cycles at beat 4. Response: beat 16'h0100 held for 3 cycles, no beat skipped or duplicated.
REQ-037 Stimulus: tx_ca_cpl_recheck=1 together with tx_rdy in REQ. Response: tx_req drops, FSM re-enters WAIT_CR, tx_st is not asserted that cycle.
REQ-038 Stimulus: sys_rst_n=0 at beat 5, then a new request. Response: all outputs 0 at once, no cpl_sent; the next TLP starts cleanly at beat 0.
